// File: rtl/uio_bus_arbiter.sv
// Two-requester arbiter for a shared bidirectional 8-bit uio pad bus.
// Define UIO_ARB_FIXED_PRIO_EN for fixed priority (A over B); default is round-robin.
module uio_bus_arbiter #(
  parameter int TURN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_done,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_done,
  output logic [7:0] rdata,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       bus_stb,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TURN,
    S_XFER,
    S_DONE
  } state_t;

  localparam logic [1:0] LP_TURN_LAST = 2'(TURN_CYCLES - 1);

  state_t     r_state;
  logic       r_dir;
  logic       r_we;
  logic       r_sel_b;
  logic [7:0] r_wdata;
  logic [1:0] r_cnt;
  logic [7:0] r_oe;
  logic [7:0] r_out;
  logic [7:0] r_rdata;
  logic       r_a_gnt;
  logic       r_b_gnt;
  logic       r_a_done;
  logic       r_b_done;
  logic       r_stb;

  logic       w_pick_a;
  logic       w_pick_b;
  logic       w_we;
  logic [7:0] w_wdata;

`ifdef UIO_ARB_FIXED_PRIO_EN
  // A always wins a contested cycle
  always_comb begin
    w_pick_a = a_req;
    w_pick_b = b_req & ~a_req;
  end
`else
  logic r_last_b;

  // Contested cycle goes to whoever was not served last
  always_comb begin
    w_pick_a = a_req & (~b_req | r_last_b);
    w_pick_b = b_req & (~a_req | ~r_last_b);
  end

  // Last-served pointer, cleared to B so A wins first after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (r_state == S_IDLE) begin
      if (w_pick_a) begin
        r_last_b <= 1'b0;
      end else if (w_pick_b) begin
        r_last_b <= 1'b1;
      end
    end
  end
`endif

  // Operation of the winner about to be latched
  always_comb begin
    w_we    = w_pick_b ? b_we : a_we;
    w_wdata = w_pick_b ? b_wdata : a_wdata;
  end

  // Main FSM; every output is registered on entry to its state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_dir    <= 1'b0;
      r_we     <= 1'b0;
      r_sel_b  <= 1'b0;
      r_wdata  <= 8'h00;
      r_cnt    <= 2'd0;
      r_oe     <= 8'h00;
      r_out    <= 8'h00;
      r_rdata  <= 8'h00;
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      r_stb    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pick_a | w_pick_b) begin
            r_sel_b <= w_pick_b;
            r_we    <= w_we;
            r_wdata <= w_wdata;
            r_a_gnt <= w_pick_a;
            r_b_gnt <= w_pick_b;
            if (r_dir != w_we) begin
              r_state <= S_TURN;
              r_cnt   <= 2'd0;
              r_oe    <= 8'h00;
            end else begin
              r_state <= S_XFER;
              r_stb   <= 1'b1;
              r_dir   <= w_we;
              if (w_we) begin
                r_oe  <= 8'hFF;
                r_out <= w_wdata;
              end else begin
                r_oe  <= 8'h00;
              end
            end
          end
        end
        S_TURN: begin
          if (r_cnt == LP_TURN_LAST) begin
            r_state <= S_XFER;
            r_stb   <= 1'b1;
            r_dir   <= r_we;
            if (r_we) begin
              r_oe  <= 8'hFF;
              r_out <= r_wdata;
            end else begin
              r_oe  <= 8'h00;
            end
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_XFER: begin
          r_state  <= S_DONE;
          r_stb    <= 1'b0;
          r_a_done <= ~r_sel_b;
          r_b_done <= r_sel_b;
          if (!r_we) begin
            r_rdata <= uio_in;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_a_gnt  <= 1'b0;
          r_b_gnt  <= 1'b0;
          r_a_done <= 1'b0;
          r_b_done <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign a_gnt   = r_a_gnt;
  assign b_gnt   = r_b_gnt;
  assign a_done  = r_a_done;
  assign b_done  = r_b_done;
  assign rdata   = r_rdata;
  assign uio_out = r_out;
  assign uio_oe  = r_oe;
  assign bus_stb = r_stb;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed vector bench for uio_bus_arbiter (TURN_CYCLES=1).
// Arbitration expectations follow UIO_ARB_FIXED_PRIO_EN when it is defined.
module tb_uio_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_wdata, b_wdata, uio_in;
  logic       a_gnt, a_done, b_gnt, b_done;
  logic [7:0] rdata, uio_out, uio_oe;
  logic       bus_stb, busy;

  int n_vec = 0;
  int n_bad = 0;

  uio_bus_arbiter #(.TURN_CYCLES(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_wdata (a_wdata),
    .a_gnt   (a_gnt),
    .a_done  (a_done),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_wdata (b_wdata),
    .b_gnt   (b_gnt),
    .b_done  (b_done),
    .rdata   (rdata),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .bus_stb (bus_stb),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       areq;
    logic       awe;
    logic [7:0] awd;
    logic       breq;
    logic       bwe;
    logic [7:0] bwd;
    logic [7:0] uin;
    logic [29:0] exp;
  } vec_t;

  vec_t v[20];

  function automatic vec_t mk(
    input logic rs, input logic ar, input logic aw, input logic [7:0] ad,
    input logic br, input logic bw, input logic [7:0] bd, input logic [7:0] ui,
    input logic ag, input logic bg, input logic adn, input logic bdn,
    input logic [7:0] rd, input logic [7:0] ou, input logic [7:0] oe,
    input logic st, input logic bz);
    vec_t t;
    t.rst  = rs;
    t.areq = ar;
    t.awe  = aw;
    t.awd  = ad;
    t.breq = br;
    t.bwe  = bw;
    t.bwd  = bd;
    t.uin  = ui;
    t.exp  = {ag, bg, adn, bdn, rd, ou, oe, st, bz};
    return t;
  endfunction

  function automatic logic [29:0] act();
    return {a_gnt, b_gnt, a_done, b_done, rdata, uio_out, uio_oe, bus_stb, busy};
  endfunction

  logic exp_ord[4];
  logic got;
  logic pa, pb;
  int   n_gnt;

  initial begin
    rst = 1'b1;
    a_req = 0; a_we = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_wdata = 0;
    uio_in = 0;

    //      rst a    we wd     b  we wd    uin    ag bg ad bd rd     out    oe    stb busy
    v[0]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v[1]  = mk(0, 1, 1, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1);
    v[2]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h5A, 8'hFF, 1, 1);
    v[3]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h5A, 8'hFF, 0, 1);
    v[4]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hFF, 0, 0);
    v[5]  = mk(0, 1, 1, 8'h11, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h11, 8'hFF, 1, 1);
    v[6]  = mk(0, 1, 1, 8'h22, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h11, 8'hFF, 0, 1);
    v[7]  = mk(0, 1, 1, 8'h22, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h11, 8'hFF, 0, 0);
    v[8]  = mk(0, 1, 1, 8'h22, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h22, 8'hFF, 1, 1);
    v[9]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h22, 8'hFF, 0, 1);
    v[10] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h22, 8'hFF, 0, 0);
    v[11] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 8'h22, 8'h00, 0, 1);
    v[12] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 8'h22, 8'h00, 1, 1);
    v[13] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'hC3, 0, 1, 0, 1, 8'hC3, 8'h22, 8'h00, 0, 1);
    v[14] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0, 0, 0, 8'hC3, 8'h22, 8'h00, 0, 0);
    v[15] = mk(0, 1, 1, 8'h77, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'hC3, 8'h22, 8'h00, 0, 1);
    v[16] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v[17] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1);
    v[18] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h44, 0, 1, 0, 1, 8'h44, 8'h00, 8'h00, 0, 1);
    v[19] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h44, 8'h00, 8'h00, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      rst     = v[i].rst;
      a_req   = v[i].areq;
      a_we    = v[i].awe;
      a_wdata = v[i].awd;
      b_req   = v[i].breq;
      b_we    = v[i].bwe;
      b_wdata = v[i].bwd;
      uio_in  = v[i].uin;
      @(posedge clk);
      #1;
      n_vec++;
      if (act() != v[i].exp) begin
        n_bad++;
        $display("FAIL vec%0d {gnt,done,rdata,out,oe,stb,busy} got=%h want=%h",
                 i, act(), v[i].exp);
      end
    end

    // Contention: both requesters reading continuously from reset
`ifdef UIO_ARB_FIXED_PRIO_EN
    exp_ord[0] = 0; exp_ord[1] = 0; exp_ord[2] = 0; exp_ord[3] = 1;
`else
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;
`endif
    rst = 1'b1;
    a_req = 0; b_req = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_req = 1; a_we = 0;
    b_req = 1; b_we = 0;
    pa = 0; pb = 0; n_gnt = 0;
    for (int c = 0; c < 60 && n_gnt < 4; c++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if ((a_gnt & b_gnt) | (a_done & b_done)) begin
        n_bad++;
        $display("FAIL overlap cyc%0d gnt=%b%b done=%b%b want no overlap",
                 c, a_gnt, b_gnt, a_done, b_done);
      end
      if ((a_gnt & ~pa) | (b_gnt & ~pb)) begin
        got = b_gnt;
        n_vec++;
        if (got != exp_ord[n_gnt]) begin
          n_bad++;
          $display("FAIL grant%0d got=%s want=%s", n_gnt,
                   got ? "B" : "A", exp_ord[n_gnt] ? "B" : "A");
        end
        n_gnt++;
`ifdef UIO_ARB_FIXED_PRIO_EN
        if (n_gnt == 3) a_req = 1'b0;
`endif
      end
      pa = a_gnt;
      pb = b_gnt;
    end
    n_vec++;
    if (n_gnt < 4) begin
      n_bad++;
      $display("FAIL grant_timeout got=%0d grants want=4", n_gnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
